ecc_encrypt_sequencer: RTL and testbench

Sequential front end for the combinational ElGamal encryption datapath. Accepts message points over a valid/ready handshake, generates a fresh ephemeral scalar k in [1, ORDER-1] from an internal LFSR by rejection sampling, and holds k and the message stable on the encryptor's inputs for a fixed multicycle settle window. It then captures the resulting ciphertext pair (C1, C2) and presents it downstream over a second valid/ready handshake.

---
 rtl/ecc_encrypt_sequencer_pkg.sv | 32 +++
 rtl/ecc_encrypt_sequencer_nonce_lfsr.sv | 52 +++++
 rtl/ecc_encrypt_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_ecc_encrypt_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_encrypt_sequencer_pkg.sv
// ecc_encrypt_sequencer_pkg
// Shared defaults for the ElGamal encryption sequencer: datapath width,
// curve subgroup order, settle window, LFSR feedback/seed and FSM encoding.
// The optional ZEROIZE_EN macro is consumed by ecc_encrypt_sequencer.sv.

package ecc_encrypt_sequencer_pkg;

    // Coordinate and scalar width of the encryptor datapath.
    localparam int DEFAULT_DATAWIDTH = 8;

    // Curve subgroup order n; a usable ephemeral scalar lies in 1..n-1.
    localparam int DEFAULT_ORDER = 19;

    // Cycles the encryptor inputs are held before the results are captured.
    localparam int DEFAULT_SETTLE_CYCLES = 4;

    // Galois LFSR feedback mask and the seed used at reset / for zero loads.
    localparam logic [7:0] DEFAULT_LFSR_TAPS = 8'hB8;
    localparam logic [7:0] DEFAULT_LFSR_SEED = 8'h01;

    // FSM state encoding, kept as plain constants for legacy tooling.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_NONCE  = 2'd1;
    localparam state_t ST_SETTLE = 2'd2;
    localparam state_t ST_OUTPUT = 2'd3;

    // Width of the saturating rejection counter.
    localparam int REJECT_CNT_W = 16;

endpackage

// File: rtl/ecc_encrypt_sequencer_nonce_lfsr.sv
// ecc_encrypt_sequencer_nonce_lfsr
// Ephemeral-scalar source for the encryption sequencer. Holds a Galois LFSR
// that steps only when the sequencer asks for a new candidate, accepts a
// seed load with priority over stepping (a zero seed is replaced by SEED so
// the register can never lock up at zero), and flags whether the current
// value is a usable scalar in 1..ORDER-1.

module ecc_encrypt_sequencer_nonce_lfsr
    import ecc_encrypt_sequencer_pkg::*;
#(
    parameter int             W     = DEFAULT_DATAWIDTH,
    parameter int             ORDER = DEFAULT_ORDER,
    parameter logic [W-1:0]   TAPS  = W'(DEFAULT_LFSR_TAPS),
    parameter logic [W-1:0]   SEED  = W'(DEFAULT_LFSR_SEED)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    input  logic         seed_load,
    input  logic [W-1:0] seed_value,
    output logic [W-1:0] value,
    output logic         candidate_ok
);

    localparam logic [W-1:0] ORDER_W = W'(ORDER);

    logic [W-1:0] step_value;
    logic [W-1:0] load_value;

    // Next LFSR value and the zero-substituted seed, both pure decode.
    always_comb begin
        step_value = value[0] ? ((value >> 1) ^ TAPS) : (value >> 1);
        load_value = (seed_value == '0) ? SEED : seed_value;
    end

    // LFSR register: reset to SEED, seed load wins over stepping.
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= SEED;
        end else if (seed_load) begin
            value <= load_value;
        end else if (advance) begin
            value <= step_value;
        end
    end

    // A candidate is usable when it lies strictly between 0 and ORDER.
    assign candidate_ok = (value != '0) && (value < ORDER_W);

endmodule

// File: rtl/ecc_encrypt_sequencer.sv
// ecc_encrypt_sequencer
// Sequential front end for the combinational ElGamal encryptor. A message
// point is accepted over msg_valid/msg_ready, a fresh scalar k in
// 1..ORDER-1 is drawn from the nonce LFSR by rejection sampling, k and the
// message are held on the encryptor inputs for SETTLE_CYCLES cycles, and the
// resulting (C1, C2) pair is registered and offered over out_valid/out_ready.
// Optional build macro: ZEROIZE_EN clears k_out on the capture edge and the
// held message on the output handshake, so secrets never outlive their use.

module ecc_encrypt_sequencer
    import ecc_encrypt_sequencer_pkg::*;
#(
    parameter int                     DATAWIDTH     = DEFAULT_DATAWIDTH,
    parameter int                     ORDER         = DEFAULT_ORDER,
    parameter int                     SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter logic [DATAWIDTH-1:0]   LFSR_TAPS     = DATAWIDTH'(DEFAULT_LFSR_TAPS),
    parameter logic [DATAWIDTH-1:0]   LFSR_SEED     = DATAWIDTH'(DEFAULT_LFSR_SEED)
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     msg_valid,
    output logic                     msg_ready,
    input  logic [DATAWIDTH-1:0]     msg_x,
    input  logic [DATAWIDTH-1:0]     msg_y,

    input  logic                     seed_load,
    input  logic [DATAWIDTH-1:0]     seed_value,

    output logic [DATAWIDTH-1:0]     k_out,
    output logic [DATAWIDTH-1:0]     Mx_out,
    output logic [DATAWIDTH-1:0]     My_out,

    input  logic [DATAWIDTH-1:0]     C1x_in,
    input  logic [DATAWIDTH-1:0]     C1y_in,
    input  logic [DATAWIDTH-1:0]     C2x_in,
    input  logic [DATAWIDTH-1:0]     C2y_in,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATAWIDTH-1:0]     C1x,
    output logic [DATAWIDTH-1:0]     C1y,
    output logic [DATAWIDTH-1:0]     C2x,
    output logic [DATAWIDTH-1:0]     C2y,

    output logic                     busy,
    output logic [REJECT_CNT_W-1:0]  reject_cnt
);

    // Settle counter counts SETTLE_CYCLES-1 down to 0.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [REJECT_CNT_W-1:0] REJECT_MAX = '1;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     settle_cnt;

    logic [DATAWIDTH-1:0] lfsr_value;
    logic                 candidate_ok;

    logic                 accept;
    logic                 nonce_eval;
    logic                 nonce_hit;
    logic                 nonce_miss;
    logic                 settle_done;
    logic                 out_fire;

    // ------------------------------------------------------------------
    // Nonce source
    // ------------------------------------------------------------------
    ecc_encrypt_sequencer_nonce_lfsr #(
        .W     (DATAWIDTH),
        .ORDER (ORDER),
        .TAPS  (LFSR_TAPS),
        .SEED  (LFSR_SEED)
    ) u_nonce_lfsr (
        .clk          (clk),
        .rst          (rst),
        .advance      (state == ST_NONCE),
        .seed_load    (seed_load),
        .seed_value   (seed_value),
        .value        (lfsr_value),
        .candidate_ok (candidate_ok)
    );

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------

    // Per-state events; a seed load in NONCE suppresses that cycle's candidate.
    always_comb begin
        accept      = (state == ST_IDLE) && msg_valid;
        nonce_eval  = (state == ST_NONCE) && !seed_load;
        nonce_hit   = nonce_eval && candidate_ok;
        nonce_miss  = nonce_eval && !candidate_ok;
        settle_done = (state == ST_SETTLE) && (settle_cnt == '0);
        out_fire    = (state == ST_OUTPUT) && out_ready;
    end

    // Next-state logic.
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept)      state_next = ST_NONCE;
            ST_NONCE:  if (nonce_hit)   state_next = ST_SETTLE;
            ST_SETTLE: if (settle_done) state_next = ST_OUTPUT;
            ST_OUTPUT: if (out_fire)    state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Settle window counter, loaded when k is chosen and run down in SETTLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (nonce_hit) begin
            settle_cnt <= SETTLE_LOAD;
        end else if ((state == ST_SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Encryptor input registers
    // ------------------------------------------------------------------

    // Message point held on the encryptor inputs for the whole request.
    always_ff @(posedge clk) begin
        if (rst) begin
            Mx_out <= '0;
            My_out <= '0;
        end else if (accept) begin
            Mx_out <= msg_x;
            My_out <= msg_y;
`ifdef ZEROIZE_EN
        end else if (out_fire) begin
            Mx_out <= '0;
            My_out <= '0;
`endif
        end
    end

    // Ephemeral scalar, latched from the first in-range LFSR candidate.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_out <= '0;
        end else if (nonce_hit) begin
            k_out <= lfsr_value;
`ifdef ZEROIZE_EN
        end else if (settle_done) begin
            k_out <= '0;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Ciphertext capture and bookkeeping
    // ------------------------------------------------------------------

    // Ciphertext registers sample the encryptor when the window closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            C1x <= '0;
            C1y <= '0;
            C2x <= '0;
            C2y <= '0;
        end else if (settle_done) begin
            C1x <= C1x_in;
            C1y <= C1y_in;
            C2x <= C2x_in;
            C2y <= C2y_in;
        end
    end

    // Saturating count of out-of-range candidates.
    always_ff @(posedge clk) begin
        if (rst) begin
            reject_cnt <= '0;
        end else if (nonce_miss && (reject_cnt != REJECT_MAX)) begin
            reject_cnt <= reject_cnt + 1'b1;
        end
    end

    // Handshake and status decodes; msg_ready is forced low during reset.
    assign msg_ready = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_OUTPUT);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_ecc_encrypt_sequencer.sv
// tb_ecc_encrypt_sequencer
// Directed bench for ecc_encrypt_sequencer with default parameters. A toy
// encryptor model is wired onto the k/M outputs; expected scalars, reject
// counts and latencies are hand-derived from the 8'hB8 Galois LFSR.
// Build with +define+ZEROIZE_EN to check the zeroizing variant.

module tb_ecc_encrypt_sequencer;

    localparam int W = 8;

`ifdef ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         msg_valid;
    logic         msg_ready;
    logic [W-1:0] msg_x, msg_y;
    logic         seed_load;
    logic [W-1:0] seed_value;
    logic [W-1:0] k_out, Mx_out, My_out;
    logic [W-1:0] C1x_in, C1y_in, C2x_in, C2y_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] C1x, C1y, C2x, C2y;
    logic         busy;
    logic [15:0]  reject_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_rcnt     = 0;

    always #5 clk = ~clk;

    // Toy encryptor: combinational function of k and M.
    assign C1x_in = k_out + 8'h40;
    assign C1y_in = k_out ^ 8'hA5;
    assign C2x_in = Mx_out ^ k_out;
    assign C2y_in = My_out + k_out;

    ecc_encrypt_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_x      (msg_x),
        .msg_y      (msg_y),
        .seed_load  (seed_load),
        .seed_value (seed_value),
        .k_out      (k_out),
        .Mx_out     (Mx_out),
        .My_out     (My_out),
        .C1x_in     (C1x_in),
        .C1y_in     (C1y_in),
        .C2x_in     (C2x_in),
        .C2y_in     (C2y_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .C1x        (C1x),
        .C1y        (C1y),
        .C2x        (C2x),
        .C2y        (C2y),
        .busy       (busy),
        .reject_cnt (reject_cnt)
    );

    typedef struct {
        logic         do_seed;
        logic [W-1:0] seed;
        logic [W-1:0] mx;
        logic [W-1:0] my;
        logic [W-1:0] exp_k;
        int           exp_rej;
        logic         hold;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_cipher(input string tag, input logic [W-1:0] k,
                                input logic [W-1:0] mx, input logic [W-1:0] my);
        check({tag, " C1x"}, C1x, k + 8'h40);
        check({tag, " C1y"}, C1y, k ^ 8'hA5);
        check({tag, " C2x"}, C2x, mx ^ k);
        check({tag, " C2y"}, C2y, my + k);
    endtask

    // Waits (bounded) for out_valid; n counts edges since the offer.
    task automatic wait_out_valid(inout int n);
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Complete the output handshake and check the IDLE turnaround.
    task automatic finish_output(input string tag, input logic [W-1:0] k,
                                 input logic [W-1:0] mx, input logic [W-1:0] my);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, out_valid, 1'b0);
        check({tag, " msg_ready back"}, msg_ready, 1'b1);
        check({tag, " busy idle"}, busy, 1'b0);
        check({tag, " k after"}, k_out, ZEROIZE ? 8'h00 : k);
        check({tag, " Mx after"}, Mx_out, ZEROIZE ? 8'h00 : mx);
        check({tag, " My after"}, My_out, ZEROIZE ? 8'h00 : my);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        int    n;
        tag = $sformatf("v%0d", idx);
        if (v.do_seed) begin
            seed_load  = 1'b1;
            seed_value = v.seed;
            @(negedge clk);
            seed_load  = 1'b0;
        end
        check({tag, " msg_ready"}, msg_ready, 1'b1);
        msg_x     = v.mx;
        msg_y     = v.my;
        msg_valid = 1'b1;
        @(negedge clk);
        n = 1;
        msg_valid = 1'b0;
        check({tag, " msg_ready drop"}, msg_ready, 1'b0);
        check({tag, " busy"}, busy, 1'b1);
        wait_out_valid(n);
        exp_rcnt += v.exp_rej;
        check({tag, " latency"}, n, 6 + v.exp_rej);
        check({tag, " k_out"}, k_out, ZEROIZE ? 8'h00 : v.exp_k);
        check({tag, " Mx_out"}, Mx_out, v.mx);
        check({tag, " reject_cnt"}, reject_cnt, exp_rcnt);
        check_cipher(tag, v.exp_k, v.mx, v.my);
        if (v.hold) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check({tag, " hold valid"}, out_valid, 1'b1);
                check({tag, " hold ready"}, msg_ready, 1'b0);
            end
            check_cipher({tag, " hold"}, v.exp_k, v.mx, v.my);
        end
        finish_output(tag, v.exp_k, v.mx, v.my);
    endtask

    initial begin
        int  n;
        logic seen_valid;

        // k=1 straight from the seed; then 21 rejects from B8..18 before 0C.
        vecs[0] = '{1'b1, 8'h01, 8'h03, 8'h06, 8'h01,  0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 8'h05, 8'h09, 8'h0C, 21, 1'b1};
        // ORDER-1 is accepted; its successor 09 is accepted too.
        vecs[2] = '{1'b1, 8'h12, 8'hA0, 8'h0F, 8'h12,  0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 8'h7E, 8'h81, 8'h09,  0, 1'b0};
        // ORDER itself is rejected: 13,B1,E0,70,38,1C then 0E.
        vecs[4] = '{1'b1, 8'h13, 8'h11, 8'h22, 8'h0E,  6, 1'b0};

        rst        = 1'b1;
        msg_valid  = 1'b0;
        msg_x      = '0;
        msg_y      = '0;
        seed_load  = 1'b0;
        seed_value = '0;
        out_ready  = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("reset msg_ready low", msg_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("reset msg_ready", msg_ready, 1'b1);
        check("reset out_valid", out_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset k_out", k_out, 8'h00);
        check("reset C1x", C1x, 8'h00);
        check("reset reject_cnt", reject_cnt, 16'h0000);

        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
        end

        // Zero seed load in NONCE: LFSR (currently 07) becomes 01, k = 1.
        msg_x = 8'h33;
        msg_y = 8'h44;
        msg_valid = 1'b1;
        @(negedge clk);
        n = 1;
        msg_valid  = 1'b0;
        seed_load  = 1'b1;
        seed_value = 8'h00;
        @(negedge clk);
        n++;
        seed_load  = 1'b0;
        check("seed0 still busy", busy, 1'b1);
        wait_out_valid(n);
        check("seed0 latency", n, 7);
        check("seed0 k_out", k_out, ZEROIZE ? 8'h00 : 8'h01);
        check("seed0 reject_cnt", reject_cnt, exp_rcnt);
        check_cipher("seed0", 8'h01, 8'h33, 8'h44);
        finish_output("seed0", 8'h01, 8'h33, 8'h44);

        // Reset during SETTLE abandons the request.
        seed_load  = 1'b1;
        seed_value = 8'h05;
        @(negedge clk);
        seed_load  = 1'b0;
        msg_x = 8'h55;
        msg_y = 8'h66;
        msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst pre k_out", k_out, 8'h05);
        rst = 1'b1;
        @(negedge clk);
        check("rst msg_ready", msg_ready, 1'b0);
        check("rst out_valid", out_valid, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst k_out", k_out, 8'h00);
        check("rst Mx_out", Mx_out, 8'h00);
        check("rst My_out", My_out, 8'h00);
        check("rst C1x", C1x, 8'h00);
        check("rst C1y", C1y, 8'h00);
        check("rst C2x", C2x, 8'h00);
        check("rst C2y", C2y, 8'h00);
        check("rst reject_cnt", reject_cnt, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        check("rst release msg_ready", msg_ready, 1'b1);
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("rst no out_valid", seen_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
